// File: rtl/lamem_model.sv
// lamem_model: simulation memory and MMIO responder for the picorv32 native
// memory bus (mem_valid/mem_ready).
//
// The model provides the following:
//   - A word-organised RAM with byte strobes.
//   - Programmable wait states.
//   - A console FIFO with a con_valid/con_ready sink.
//   - A sticky EXIT register.
//   - A free-running cycle counter.
//   - An err pulse on out-of-range accesses.
//
// Optional feature macro: LAMEM_FETCH_COUNT_EN.
//   - When it is defined, an instruction-fetch counter is added.
//   - The counter is readable at MMIO_BASE+12.
//   - When it is undefined, that address decodes as out-of-range.
//
// RAM contents survive resetn. Reset aborts an in-flight request silently.
module lamem_model #(
    parameter int          MEM_WORDS   = 65536,
    parameter string       MEM_INIT    = "",
    parameter int          WAIT_CYCLES = 0,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_data,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        err
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [29:0] CON_WORD   = MMIO_BASE[31:2];
    localparam logic [29:0] EXIT_WORD  = CON_WORD + 30'd1;
    localparam logic [29:0] CYC_WORD   = CON_WORD + 30'd2;
    localparam logic [29:0] FETCH_WORD = CON_WORD + 30'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_STALL} state_t;

    state_t        state_reg, state_next;

    // Latched request; it stays stable from sampling until the response.
    logic [29:0]   req_word_reg;
    logic [31:0]   req_wdata_reg;
    logic [3:0]    req_wstrb_reg;
    logic [3:0]    wcnt_reg;

    // Response registers.
    logic          mem_ready_reg, ready_next;
    logic          err_reg, err_next;
    logic          rsel_ram_reg, rsel_ram_next;
    logic [31:0]   mmio_rdata_reg, mmio_rdata_next;

    // RAM storage.
    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   ram_rd_reg;
    logic [AW-1:0] ram_idx;
    logic          ram_we;

    // Console FIFO.
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          fifo_full, fifo_empty, push, pop;

    logic          exit_valid_reg, exit_we;
    logic [31:0]   exit_code_reg;
    logic [31:0]   cyc_reg;

    logic take;
    logic is_wr, is_ram, is_con, is_exit, is_cyc, is_fetch, is_oor, con_wr;
    logic unused_ok;

`ifdef LAMEM_FETCH_COUNT_EN
    logic          req_instr_reg;
    logic [31:0]   fetch_cnt_reg;
    assign is_fetch  = (req_word_reg == FETCH_WORD);
    assign unused_ok = ^mem_addr[1:0];
`else
    assign is_fetch  = 1'b0;
    assign unused_ok = ^{mem_addr[1:0], mem_instr};
`endif

    // A request is accepted only from IDLE.
    // IDLE ignores the cycle where the previous response is still visible,
    // because the master has not yet dropped mem_valid in that cycle.
    assign take = (state_reg == ST_IDLE) && mem_valid && !mem_ready_reg;

    // Address decode on the latched word address. RAM takes priority.
    assign is_wr   = |req_wstrb_reg;
    assign is_ram  = (req_word_reg >> AW) == '0;
    assign is_con  = !is_ram && (req_word_reg == CON_WORD);
    assign is_exit = !is_ram && (req_word_reg == EXIT_WORD);
    assign is_cyc  = !is_ram && (req_word_reg == CYC_WORD);
    assign is_oor  = !(is_ram || is_con || is_exit || is_cyc || (is_fetch && !is_ram));
    assign con_wr  = is_con && is_wr;
    assign ram_idx = req_word_reg[AW-1:0];

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (PW+1)'(FIFO_DEPTH));
    assign pop        = con_valid && con_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (take) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT:  if (wcnt_reg <= 4'd1) state_next = ST_RESP;
            ST_RESP:  state_next = (con_wr && fifo_full) ? ST_STALL : ST_IDLE;
            ST_STALL: if (!fifo_full) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output and datapath strobes. The access itself happens only in RESP/STALL.
    always_comb begin
        ready_next      = 1'b0;
        err_next        = 1'b0;
        push            = 1'b0;
        ram_we          = 1'b0;
        exit_we         = 1'b0;
        rsel_ram_next   = 1'b0;
        mmio_rdata_next = '0;
        case (state_reg)
            ST_RESP: begin
                if (con_wr) begin
                    if (!fifo_full) begin
                        push       = 1'b1;
                        ready_next = 1'b1;
                    end
                end else begin
                    ready_next = 1'b1;
                    err_next   = is_oor;
                    ram_we     = is_ram && is_wr;
                    exit_we    = is_exit && is_wr;
                    if (!is_wr) begin
                        if (is_ram)       rsel_ram_next   = 1'b1;
                        else if (is_exit) mmio_rdata_next = exit_code_reg;
                        else if (is_cyc)  mmio_rdata_next = cyc_reg;
`ifdef LAMEM_FETCH_COUNT_EN
                        else if (is_fetch) mmio_rdata_next = fetch_cnt_reg;
`endif
                        else if (is_oor)  mmio_rdata_next = 32'hDEAD_BEEF;
                    end
                end
            end
            ST_STALL: begin
                if (!fifo_full) begin
                    push       = 1'b1;
                    ready_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Latch the request and run the wait-state down-counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_word_reg  <= '0;
            req_wdata_reg <= '0;
            req_wstrb_reg <= '0;
            wcnt_reg      <= '0;
        end else if (take) begin
            req_word_reg  <= mem_addr[31:2];
            req_wdata_reg <= mem_wdata;
            req_wstrb_reg <= mem_wstrb;
            wcnt_reg      <= 4'(WAIT_CYCLES);
        end else if (state_reg == ST_WAIT) begin
            wcnt_reg      <= wcnt_reg - 4'd1;
        end
    end

`ifdef LAMEM_FETCH_COUNT_EN
    // Count completed instruction fetches (counted in the mem_ready cycle).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_instr_reg <= 1'b0;
            fetch_cnt_reg <= '0;
        end else begin
            if (take) req_instr_reg <= mem_instr;
            if (mem_ready_reg && req_instr_reg) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end
`endif

    // Response registers: ready, err and rdata are all zero outside the ready cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready_reg  <= 1'b0;
            err_reg        <= 1'b0;
            rsel_ram_reg   <= 1'b0;
            mmio_rdata_reg <= '0;
        end else begin
            mem_ready_reg  <= ready_next;
            err_reg        <= err_next;
            rsel_ram_reg   <= rsel_ram_next;
            mmio_rdata_reg <= mmio_rdata_next;
        end
    end

    // RAM: byte-lane write, registered read. There is no reset, so the contents
    // survive resetn.
    always_ff @(posedge clk) begin
        if (ram_we && resetn) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb_reg[b]) ram[ram_idx][b*8 +: 8] <= req_wdata_reg[b*8 +: 8];
            end
        end
        ram_rd_reg <= ram[ram_idx];
    end

    // Console FIFO storage.
    always_ff @(posedge clk) begin
        if (push && resetn) fifo_mem[wr_ptr_reg] <= req_wdata_reg[7:0];
    end

    // Console FIFO pointers and the occupancy count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // EXIT register (sticky until reset) and the free-running cycle counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exit_valid_reg <= 1'b0;
            exit_code_reg  <= '0;
            cyc_reg        <= '0;
        end else begin
            cyc_reg <= cyc_reg + 32'd1;
            if (exit_we) begin
                exit_valid_reg <= 1'b1;
                exit_code_reg  <= req_wdata_reg;
            end
        end
    end

    assign mem_ready  = mem_ready_reg;
    assign mem_rdata  = rsel_ram_reg ? ram_rd_reg : mmio_rdata_reg;
    assign err        = err_reg;
    assign con_valid  = !fifo_empty;
    assign con_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg];
    assign exit_valid = exit_valid_reg;
    assign exit_code  = exit_code_reg;

endmodule

// File: tb/tb_lamem_model.sv
// tb_lamem_model: directed test of lamem_model.
// The DUT is built with 3 wait states and a 4-entry console FIFO.
// Each bus transaction prints one line.
module tb_lamem_model;

    localparam int          W    = 3;
    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        con_valid, con_ready;
    logic [7:0]  con_data;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    lamem_model #(
        .MEM_WORDS  (1024),
        .WAIT_CYCLES(W),
        .FIFO_DEPTH (4),
        .MMIO_BASE  (MMIO)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .con_data  (con_data),
        .exit_valid(exit_valid),
        .exit_code (exit_code),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One bus transaction. It starts 1 time unit after a rising edge and
    // checks that the latency is W+2 cycles.
    // It then checks that ready, err and rdata are back to 0 one cycle later.
    task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr,
                       output logic [31:0] rdata, output logic err_seen);
        int lat;
        bit done;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = instr;
        lat = 0;
        done = 1'b0;
        rdata = '0;
        err_seen = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready) begin
                done = 1'b1;
                rdata = mem_rdata;
                err_seen = err;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0;
        mem_instr = 1'b0;
        $display("%s addr=%h wstrb=%b wdata=%h rdata=%h err=%0b lat=%0d",
                 tag, addr, wstrb, wdata, rdata, err_seen, lat);
        check({tag, "_lat"}, 32'(lat), 32'(W + 2));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {30'b0, mem_ready, err}, 32'h0);
        check({tag, "_rdata_idle"}, mem_rdata, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   32'(mem_ready),  32'h0);
        check({tag, "_rdata"},   mem_rdata,       32'h0);
        check({tag, "_conv"},    32'(con_valid),  32'h0);
        check({tag, "_cond"},    32'(con_data),   32'h0);
        check({tag, "_exitv"},   32'(exit_valid), 32'h0);
        check({tag, "_exitc"},   exit_code,       32'h0);
        check({tag, "_err"},     32'(err),        32'h0);
    endtask

    initial begin
        logic [31:0] rd, c1, c2;
        logic        e;
        int          nready, ready_at;
        logic [7:0]  drained[$];

        resetn = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        con_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Byte-strobe write over a known word.
        bus("wr_init",  32'h100, 32'h1122_3344, 4'b1111, 1'b0, rd, e);
        bus("wr_strb",  32'h100, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, e);
        bus("rd_strb",  32'h100, 32'h0,         4'b0000, 1'b0, rd, e);
        check("strb_data", rd, 32'h11BB_33DD);

        // Back-to-back wait-state reads of 0x0, 0x4, 0x8.
        for (int i = 0; i < 3; i++) bus("wr_word", 32'(i * 4), 32'hA0 + 32'(i * 4), 4'hF, 1'b0, rd, e);
        for (int i = 0; i < 3; i++) begin
            bus("rd_word", 32'(i * 4), 32'h0, 4'h0, 1'b0, rd, e);
            check("word_data", rd, 32'hA0 + 32'(i * 4));
        end

        // Console backpressure: four writes fill the FIFO and the fifth stalls.
        for (int i = 0; i < 4; i++) bus("con_wr", MMIO, 32'h41 + 32'(i), 4'b0001, 1'b0, rd, e);
        check("con_valid_full", 32'(con_valid), 32'h1);
        check("con_head", 32'(con_data), 32'h41);
        mem_valid = 1'b1;
        mem_addr  = MMIO;
        mem_wdata = 32'h45;
        mem_wstrb = 4'b0001;
        nready = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_ready) nready++;
        end
        $display("con_wr addr=%h wdata=%h stalled readies=%0d", MMIO, 32'h45, nready);
        check("stall_no_ready", 32'(nready), 32'h0);
        check("stall_head_stable", 32'(con_data), 32'h41);
        con_ready = 1'b1;
        ready_at = 0;
        for (int i = 1; i <= 20; i++) begin
            if (con_valid) drained.push_back(con_data);
            @(posedge clk); #1;
            if (mem_ready && ready_at == 0) begin
                ready_at = i;
                mem_valid = 1'b0;
                mem_wstrb = 4'b0;
            end
        end
        con_ready = 1'b0;
        check("stall_release_cycle", 32'(ready_at), 32'd2);
        check("drain_count", 32'(drained.size()), 32'd5);
        for (int k = 0; k < drained.size(); k++) check("drain_order", 32'(drained[k]), 32'h41 + 32'(k));
        check("con_empty", 32'(con_valid), 32'h0);

        // EXIT register and an out-of-range access.
        bus("wr_exit", MMIO + 32'd4, 32'h1, 4'hF, 1'b0, rd, e);
        check("exit_valid", 32'(exit_valid), 32'h1);
        check("exit_code", exit_code, 32'h1);
        bus("rd_oor", 32'h2000_0000, 32'h0, 4'h0, 1'b0, rd, e);
        check("oor_data", rd, 32'hDEAD_BEEF);
        check("oor_err", 32'(e), 32'h1);
        check("exit_sticky", {exit_code[30:0], exit_valid}, 32'h3);
        bus("rd_exit", MMIO + 32'd4, 32'h0, 4'h0, 1'b0, rd, e);
        check("exit_rd", rd, 32'h1);
        bus("rd_con", MMIO, 32'h0, 4'h0, 1'b0, rd, e);
        check("con_rd_zero", rd, 32'h0);
        check("con_rd_err", 32'(e), 32'h0);

        // Two cycle-counter reads whose RESP edges are 10 cycles apart.
        bus("rd_cyc", MMIO + 32'd8, 32'h0, 4'h0, 1'b0, c1, e);
        repeat (4) @(posedge clk);
        #1;
        bus("rd_cyc", MMIO + 32'd8, 32'h0, 4'h0, 1'b0, c2, e);
        check("cyc_delta", c2 - c1, 32'd10);

        // Three instruction fetches, then the fetch-count address.
        for (int i = 0; i < 3; i++) bus("fetch", 32'h0, 32'h0, 4'h0, 1'b1, rd, e);
        bus("rd_fetch", MMIO + 32'd12, 32'h0, 4'h0, 1'b0, rd, e);
`ifdef LAMEM_FETCH_COUNT_EN
        check("fetch_count", rd, 32'd3);
        check("fetch_err", 32'(e), 32'h0);
`else
        check("fetch_oor", rd, 32'hDEAD_BEEF);
        check("fetch_err", 32'(e), 32'h1);
`endif

        // Reset while a write to 0x100 is sitting in WAIT.
        mem_valid = 1'b1;
        mem_addr  = 32'h100;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;
        nready = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (mem_ready) nready++;
        end
        resetn = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_ready) nready++;
        end
        $display("wr_abort addr=%h wdata=%h readies=%0d", 32'h100, 32'hFFFF_FFFF, nready);
        check("abort_no_ready", 32'(nready), 32'h0);
        check_reset_outputs("rst2");
        resetn = 1'b1;
        bus("rd_cyc_rst", MMIO + 32'd8, 32'h0, 4'h0, 1'b0, rd, e);
        check("cyc_after_rst", rd, 32'd4);
        bus("rd_keep", 32'h100, 32'h0, 4'h0, 1'b0, rd, e);
        check("ram_kept", rd, 32'h11BB_33DD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
